// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: rider FSM states, screen/coordinate constants
// and the 11-to-12 bit sign-extension helper used by the overlap tests.
package frogger_pkg;

    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 11;

    typedef enum logic [1:0] {
        IDLE,
        RIDING,
        GRACE,
        DROWNED
    } rider_state_t;

    function automatic logic signed [COORD_W:0] sext12(input logic [COORD_W-1:0] v);
        return {v[COORD_W-1], v};
    endfunction

endpackage

// File: rtl/lilypad_rider_if.sv
// Frog/lilypad geometry in, carry and drown status out; master is the frog
// controller side, slave is the rider.
interface lilypad_rider_if;
    import frogger_pkg::*;

    logic [COORD_W-1:0] FrogX;
    logic [COORD_W-1:0] FrogY;
    logic [COORD_W-1:0] FrogW;
    logic [COORD_W-1:0] FrogH;
    logic [COORD_W-1:0] LPadX;
    logic [COORD_W-1:0] LPadY;
    logic [COORD_W-1:0] LPad_Width;
    logic [COORD_W-1:0] LPad_Height;
    logic               In_River;
    logic               Frog_Hop;
    logic               Respawn;
    logic [COORD_W-1:0] Carry_DX;
    logic               Riding;
    logic               Drown;
    logic               Drowned;

    modport master (
        output FrogX, FrogY, FrogW, FrogH,
        output LPadX, LPadY, LPad_Width, LPad_Height,
        output In_River, Frog_Hop, Respawn,
        input  Carry_DX, Riding, Drown, Drowned
    );

    modport slave (
        input  FrogX, FrogY, FrogW, FrogH,
        input  LPadX, LPadY, LPad_Width, LPad_Height,
        input  In_River, Frog_Hop, Respawn,
        output Carry_DX, Riding, Drown, Drowned
    );

endinterface

// File: rtl/box_contains.sv
// Combinational signed point-in-rectangle test on 12-bit coordinates;
// the right and bottom edges are exclusive.
module box_contains (
    input  logic signed [11:0] pointX_i,
    input  logic signed [11:0] pointY_i,
    input  logic signed [11:0] boxX_i,
    input  logic signed [11:0] boxY_i,
    input  logic signed [11:0] boxW_i,
    input  logic signed [11:0] boxH_i,
    output logic               inside_o
);

    logic signed [11:0] boxRight;
    logic signed [11:0] boxBottom;

    assign boxRight  = boxX_i + boxW_i;
    assign boxBottom = boxY_i + boxH_i;

    assign inside_o = (pointX_i >= boxX_i) && (pointX_i < boxRight) &&
                      (pointY_i >= boxY_i) && (pointY_i < boxBottom);

endmodule

// File: rtl/lilypad_rider.sv
// Decides each frame whether the frog rides the lilypad, emits the pad's
// per-frame X carry, and runs the off-pad grace timer that ends in a drowning.
module lilypad_rider
    import frogger_pkg::*;
#(
    parameter int GRACE_FRAMES = 2,
    parameter int MAX_STEP     = 16
) (
    input  logic           Reset,
    input  logic           frame_clk,
    lilypad_rider_if.slave bus
);

    localparam logic [2:0] GRACE_LIMIT = 3'(GRACE_FRAMES);
    localparam logic signed [COORD_W-1:0] STEP_POS = COORD_W'(MAX_STEP);
    localparam logic signed [COORD_W-1:0] STEP_NEG = -STEP_POS;

    rider_state_t          state_q, state_d;
    logic [2:0]            grace_q, grace_d;
    logic [COORD_W-1:0]    prevX_q;
    logic                  prevValid_q;
    logic [COORD_W-1:0]    carryDx_q, carryDx_d;
    logic                  riding_q, riding_d;
    logic                  drown_q, drown_d;
    logic                  drowned_q, drowned_d;

    logic signed [COORD_W:0]   centreX;
    logic signed [COORD_W:0]   centreY;
    logic                      onPad;
    logic signed [COORD_W-1:0] padDelta;
    logic signed [COORD_W-1:0] deltaEff;

    assign centreX = sext12(bus.FrogX) + sext12({1'b0, bus.FrogW[COORD_W-1:1]});
    assign centreY = sext12(bus.FrogY) + sext12({1'b0, bus.FrogH[COORD_W-1:1]});

    box_contains uPadTest (
        .pointX_i (centreX),
        .pointY_i (centreY),
        .boxX_i   (sext12(bus.LPadX)),
        .boxY_i   (sext12(bus.LPadY)),
        .boxW_i   (sext12(bus.LPad_Width)),
        .boxH_i   (sext12(bus.LPad_Height)),
        .inside_o (onPad)
    );

    // Large jumps are screen-wrap teleports, not motion the frog should follow.
    always_comb begin
        padDelta = bus.LPadX - prevX_q;
        deltaEff = padDelta;
        if (!prevValid_q || (padDelta > STEP_POS) || (padDelta < STEP_NEG)) begin
            deltaEff = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grace_d   = '0;
        if (state_q == DROWNED) begin
            state_d = bus.Respawn ? IDLE : DROWNED;
        end else if (bus.Frog_Hop || !bus.In_River) begin
            state_d = IDLE;
        end else if (onPad) begin
            state_d = RIDING;
        end else if (grace_q >= GRACE_LIMIT) begin
            state_d = DROWNED;
        end else begin
            state_d = GRACE;
            grace_d = (grace_q == 3'd7) ? 3'd7 : grace_q + 3'd1;
        end

        carryDx_d = (state_d == RIDING) ? deltaEff : '0;
        riding_d  = (state_d == RIDING);
        drowned_d = (state_d == DROWNED);
        drown_d   = (state_d == DROWNED) && (state_q != DROWNED);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            grace_q     <= '0;
            prevX_q     <= '0;
            prevValid_q <= 1'b0;
            carryDx_q   <= '0;
            riding_q    <= 1'b0;
            drown_q     <= 1'b0;
            drowned_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grace_q     <= grace_d;
            prevX_q     <= bus.LPadX;
            prevValid_q <= 1'b1;
            carryDx_q   <= carryDx_d;
            riding_q    <= riding_d;
            drown_q     <= drown_d;
            drowned_q   <= drowned_d;
        end
    end

    assign bus.Carry_DX = carryDx_q;
    assign bus.Riding   = riding_q;
    assign bus.Drown    = drown_q;
    assign bus.Drowned  = drowned_q;

endmodule

// File: doc/lilypad_rider.md
# lilypad_rider

Consumer of a lilypad mover's position/size outputs. Each frame it checks whether the frog sits on a lilypad and, while riding, emits a signed per-frame carry delta that the frog controller adds to frog X. When the frog is in a river row, not on a pad and not mid-hop, it runs a short grace timer and then declares a drowning. It sits between one lilypad instance and the frog motion controller, clocked by frame_clk.

## Interface
- GRACE_FRAMES, 2: consecutive off-pad river frames tolerated before drowning
- MAX_STEP, 16: largest |pad ΔX| accepted as motion; larger deltas are wrap teleports
- Reset  in  1: asynchronous, active-high
- frame_clk  in  1: frame clock, one edge per video frame
- FrogX, FrogY  in  11: frog top-left, 11-bit two's complement
- FrogW, FrogH  in  11: frog size
- LPadX, LPadY  in  11: lilypad top-left, 11-bit two's complement (off-screen left values such as 1968 and 2008 are negative)
- LPad_Width, LPad_Height  in  11: lilypad size
- In_River  in  1: frog's current row is water
- Frog_Hop  in  1: frog is airborne this frame
- Respawn  in  1: frog controller has respawned the frog; clears DROWNED
- Carry_DX  out  11: two's complement X delta for the frog, registered
- Riding  out  1: frog is on the pad, registered
- Drown  out  1: one-frame pulse when drowning is declared
- Drowned  out  1: level; high while in DROWNED

## Operation
- States: IDLE, RIDING, GRACE, DROWNED.
- Centre test: cx = FrogX + (FrogW>>1), cy = FrogY + (FrogH>>1). All operands are sign-extended to 12 bits. on_pad = (LPadX ≤ cx < LPadX+LPad_Width) and (LPadY ≤ cy < LPadY+LPad_Height). All comparisons are signed.
- Pad delta: prev_x holds the pad X from the previous frame. delta = LPadX − prev_x, 11-bit modular, interpreted signed.
  - If |delta| > MAX_STEP, delta_eff = 0. This covers wrap teleports such as 2008→640 and 640→1968.
  - On the first frame after reset, prev_valid = 0 and delta_eff = 0.
- Transitions, evaluated every edge in priority order:
  - DROWNED: stay until Respawn=1, then go to IDLE.
  - Frog_Hop=1: from any other state, go to IDLE. No drown evaluation while airborne.
  - In_River=0: go to IDLE.
  - on_pad=1: go to RIDING. The grace counter clears.
  - Otherwise: go to GRACE and increment the grace counter. When the counter reaches GRACE_FRAMES, go to DROWNED instead and pulse Drown.
- Carry_DX <= delta_eff when the next state is RIDING, otherwise 0.
- Riding <= (next state == RIDING).
- Drowned <= (next state == DROWNED).
- Grace counter is 3 bits and saturates. It clears on any transition that does not enter GRACE.

## Timing
- Reset values:
  - State: IDLE
  - Carry_DX: 0
  - Riding, Drown, Drowned: 0
  - Grace counter: 0
  - prev_x: 0, prev_valid: 0
- Reset mid-ride drops immediately to IDLE with Carry_DX = 0.
- Latency: pad moves on edge k. The delta is seen combinationally during frame k and appears on Carry_DX after edge k+1. Carry_DX therefore lags pad motion by exactly one frame.
- prev_x <= LPadX on every edge outside reset, including in DROWNED. prev_valid <= 1.
- Drown is high for exactly one frame. Drowned rises on the same edge as Drown.
- Respawn and on_pad in the same frame while DROWNED: Respawn wins and the next state is IDLE. Riding is evaluated on the following edge.
- Hop landing: Frog_Hop 1→0 with on_pad=1 enters RIDING on that edge. With on_pad=0 it enters GRACE.

## Structure
- Shared package frogger_pkg holds:
  - rider_state_t enum
  - SCREEN_W = 640
  - a COORD_W = 11 constant
  - a signed-extend helper function for 11→12 bit
- One sub-module, box_contains: combinational, 12-bit signed point-in-rectangle test. It is instantiated once for the X/Y centre test and is reusable by car collision logic.
- Target size is about 150–200 lines of RTL.

## Test plan
- Riding carry: pad at (200,100) 40×40 stepping −10 every 4th frame; frog (210,110) 20×20, In_River=1. Required: Riding=1; Carry_DX = 11'h7F6 (−10) one frame after each pad step, 0 on the other frames.
- Wrap suppression: ride a pad whose X goes 2008→640. Required: Carry_DX = 0 on that frame and Riding drops on the next evaluation because the frog centre is off the pad. A right-moving pad going 640→1968 likewise gives Carry_DX = 0.
- Drown with grace: frog at (400,110), pad far away, In_River=1, Frog_Hop=0. Required: GRACE for 2 frames, then Drown high for exactly 1 frame on the 3rd edge, Drowned held until Respawn=1, then IDLE.
- Hop exemption: same off-pad placement with Frog_Hop=1 for 5 frames. Required: no Drown and Carry_DX = 0. After Frog_Hop drops with the frog landing on the pad, Riding=1 on the next edge.
- Reset mid-ride: assert Reset asynchronously between edges while Riding=1. Required: Riding, Carry_DX and Drowned = 0 immediately, and the first post-reset delta is forced to 0.
- Signed edge: pad X = 2030 (−18), width 40; frog centre X = 5. Required: on_pad=1 and Riding=1.
